// File: rtl/openfire_fsl_hub_pkg.sv
// openfire_fsl_hub_pkg: shared FSM states, channel-select width and log2 helper
package openfire_fsl_hub_pkg;
  localparam int CH_W = 3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/openfire_fsl_hub_fifo.sv
// openfire_fsl_hub_fifo: per-channel master FIFO; caller guarantees no push when full, no pop when empty
module openfire_fsl_hub_fifo
  import openfire_fsl_hub_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic [clog2(DEPTH):0] count_o,
  output logic                  empty_o
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  // storage needs no reset: an empty FIFO never exposes its head
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/openfire_fsl_hub.sv
// openfire_fsl_hub: multi-channel FSL hub with blocking/non-blocking put/get
// and per-channel master FIFOs that drain independently of the request FSM.
module openfire_fsl_hub
  import openfire_fsl_hub_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req_i,
  input  logic                       cpu_get_i,
  input  logic [CH_W-1:0]            cpu_ch_i,
  input  logic                       cpu_blocking_i,
  input  logic                       cpu_control_i,
  input  logic [DATA_W-1:0]          cpu_wdata_i,
  output logic                       cpu_stall_o,
  output logic                       cpu_done_o,
  output logic [DATA_W-1:0]          cpu_rdata_o,
  output logic                       cpu_carry_o,
  output logic                       cpu_ctrl_err_o,
  output logic [NUM_CH*DATA_W-1:0]   fsl_m_data_o,
  output logic [NUM_CH-1:0]          fsl_m_control_o,
  output logic [NUM_CH-1:0]          fsl_m_write_o,
  input  logic [NUM_CH-1:0]          fsl_m_full_i,
  input  logic [NUM_CH*DATA_W-1:0]   fsl_s_data_i,
  input  logic [NUM_CH-1:0]          fsl_s_control_i,
  input  logic [NUM_CH-1:0]          fsl_s_exists_i,
  output logic [NUM_CH-1:0]          fsl_s_read_o
);
  localparam int CW = clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic get_q, blk_q, ctl_q, carry_q, carry_d, cerr_q, cerr_d;
  logic [CH_W-1:0] ch_q, cur_ch;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d, cur_wdata, sel_sdata;
  logic idle, active, cur_get, cur_blk, cur_ctl, valid_ch;
  logic sel_exists, sel_space, sel_sctl, ready, fire;
  logic [CW-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] empty;
  // in IDLE the live request is evaluated so the action lands in the request cycle
  assign idle      = state_q == ST_IDLE;
  assign active    = (idle & cpu_req_i) | (state_q == ST_WAIT);
  assign cur_get   = idle ? cpu_get_i : get_q;
  assign cur_ch    = idle ? cpu_ch_i : ch_q;
  assign cur_blk   = idle ? cpu_blocking_i : blk_q;
  assign cur_ctl   = idle ? cpu_control_i : ctl_q;
  assign cur_wdata = idle ? cpu_wdata_i : wdata_q;
  assign valid_ch  = int'(cur_ch) < NUM_CH;
  always_comb begin
    sel_exists = 1'b0;
    sel_space  = 1'b0;
    sel_sctl   = 1'b0;
    sel_sdata  = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (cur_ch == CH_W'(i)) begin
        sel_exists = fsl_s_exists_i[i];
        sel_space  = cnt[i] < CW'(DEPTH);
        sel_sctl   = fsl_s_control_i[i];
        sel_sdata  = fsl_s_data_i[i*DATA_W +: DATA_W];
      end
  end
  assign ready = valid_ch & (cur_get ? sel_exists : sel_space);
  assign fire  = active & ready;
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    carry_d     = carry_q;
    cerr_d      = cerr_q;
    cpu_stall_o = state_q == ST_WAIT;
    if (active & (fire | ~valid_ch | ~cur_blk)) begin
      state_d = ST_RESP;
      rdata_d = (fire & cur_get) ? sel_sdata : '0;
      carry_d = ~fire;
      cerr_d  = fire & cur_get & (sel_sctl ^ cur_ctl);
    end else if (active) begin
      state_d     = ST_WAIT;
      cpu_stall_o = 1'b1;
    end
    if (state_q == ST_RESP) state_d = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      get_q   <= 1'b0;
      ch_q    <= '0;
      blk_q   <= 1'b0;
      ctl_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      carry_q <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      carry_q <= carry_d;
      cerr_q  <= cerr_d;
      if (idle & cpu_req_i) begin
        get_q   <= cpu_get_i;
        ch_q    <= cpu_ch_i;
        blk_q   <= cpu_blocking_i;
        ctl_q   <= cpu_control_i;
        wdata_q <= cpu_wdata_i;
      end
    end
  end
  assign cpu_done_o     = state_q == ST_RESP;
  assign cpu_rdata_o    = cpu_done_o ? rdata_q : '0;
  assign cpu_carry_o    = cpu_done_o & carry_q;
  assign cpu_ctrl_err_o = cpu_done_o & cerr_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W:0] head;
    logic hit, pop;
    assign hit              = fire & (cur_ch == CH_W'(i));
    assign fsl_s_read_o[i]  = hit & cur_get;
    assign pop              = ~empty[i] & ~fsl_m_full_i[i];
    assign fsl_m_write_o[i] = pop;
    assign {fsl_m_control_o[i], fsl_m_data_o[i*DATA_W +: DATA_W]} = empty[i] ? '0 : head;
    openfire_fsl_hub_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (hit & ~cur_get),
      .din_i   ({cur_ctl, cur_wdata}),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (cnt[i]),
      .empty_o (empty[i])
    );
  end
endmodule

// File: tb/tb_openfire_fsl_hub.sv
// tb_openfire_fsl_hub: directed and randomized checks against a queue-based link model.
module tb_openfire_fsl_hub;
  logic clk = 0, rst_n = 0;
  logic cpu_req = 0, cpu_get = 0, cpu_blocking = 0, cpu_control = 0;
  logic [2:0] cpu_ch = 0;
  logic [31:0] cpu_wdata = 0, cpu_rdata;
  logic cpu_stall, cpu_done, cpu_carry, cpu_ctrl_err;
  logic [127:0] fsl_m_data, fsl_s_data = 0;
  logic [3:0] fsl_m_control, fsl_m_write, fsl_m_full = 0;
  logic [3:0] fsl_s_control = 0, fsl_s_exists = 0, fsl_s_read;
  int checks = 0, errors = 0;
  logic [32:0] mq [4][$];

  always #5 clk = ~clk;

  openfire_fsl_hub #(.NUM_CH(4), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req_i(cpu_req), .cpu_get_i(cpu_get), .cpu_ch_i(cpu_ch),
    .cpu_blocking_i(cpu_blocking), .cpu_control_i(cpu_control), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(cpu_stall), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata),
    .cpu_carry_o(cpu_carry), .cpu_ctrl_err_o(cpu_ctrl_err), .fsl_m_data_o(fsl_m_data),
    .fsl_m_control_o(fsl_m_control), .fsl_m_write_o(fsl_m_write), .fsl_m_full_i(fsl_m_full),
    .fsl_s_data_i(fsl_s_data), .fsl_s_control_i(fsl_s_control), .fsl_s_exists_i(fsl_s_exists),
    .fsl_s_read_o(fsl_s_read)
  );

  // link monitor: every master write must be legal and match the model's oldest word
  always begin
    @(negedge clk);
    #2;
    for (int c = 0; c < 4; c++)
      if (fsl_m_write[c]) begin
        checks++;
        if (fsl_m_full[c]) begin
          errors++;
          $display("FAIL link_write_while_full ch%0d", c);
        end else if (mq[c].size() == 0) begin
          errors++;
          $display("FAIL link_unexpected_write ch%0d got %h", c, {fsl_m_control[c], fsl_m_data[c*32 +: 32]});
        end else begin
          if ({fsl_m_control[c], fsl_m_data[c*32 +: 32]} !== mq[c][0]) begin
            errors++;
            $display("FAIL link_word ch%0d got %h want %h", c, {fsl_m_control[c], fsl_m_data[c*32 +: 32]}, mq[c][0]);
          end
          void'(mq[c].pop_front());
        end
      end
  end

  task automatic start_req(input logic g, input logic [2:0] c, input logic b, input logic ct,
                           input logic [31:0] wd, output logic st, output logic [3:0] rd);
    cpu_req = 1; cpu_get = g; cpu_ch = c; cpu_blocking = b; cpu_control = ct; cpu_wdata = wd;
    #1;
    st = cpu_stall;
    rd = fsl_s_read;
    @(negedge clk);
    cpu_req = 0;
  endtask

  task automatic wait_done(input int budget, output int n, output logic [31:0] rdv,
                           output logic cy, output logic ce);
    n = 0;
    #1;
    while (!cpu_done && n >= 0) begin
      if (n == budget) n = -1;
      else begin
        n++;
        @(negedge clk);
        #1;
      end
    end
    rdv = cpu_rdata; cy = cpu_carry; ce = cpu_ctrl_err;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_stall, cpu_done, cpu_carry, cpu_ctrl_err, cpu_rdata, fsl_m_write, fsl_s_read, fsl_m_data, fsl_m_control} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero stall=%b done=%b mw=%b sr=%b", cpu_stall, cpu_done, fsl_m_write, fsl_s_read);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_put_basic;
    logic st; logic [3:0] rd;
    @(negedge clk);
    fsl_m_full = 0;
    mq[1].push_back({1'b0, 32'hDEADBEEF});
    start_req(0, 1, 1, 0, 32'hDEADBEEF, st, rd);
    #1;
    checks++;
    if (st !== 0 || cpu_done !== 1 || cpu_carry !== 0) begin
      errors++;
      $display("FAIL put_basic_done stall=%b done=%b carry=%b want 0 1 0", st, cpu_done, cpu_carry);
    end
    checks++;
    if (fsl_m_write[1] !== 1 || fsl_m_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL put_basic_link write=%b data=%h want 1 deadbeef", fsl_m_write[1], fsl_m_data[63:32]);
    end
  endtask

  task automatic test_fill_blocking;
    logic st, cy, ce; logic [3:0] rd; logic [31:0] rdv; int n;
    @(negedge clk);
    fsl_m_full[0] = 1;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d = $urandom;
      if (mq[0].size() < 4) mq[0].push_back({i[0], d});
      start_req(0, 0, 0, i[0], d, st, rd);
      wait_done(3, n, rdv, cy, ce);
      checks++;
      if (n !== 0 || cy !== (i == 4)) begin
        errors++;
        $display("FAIL fill_nb_put%0d latency=%0d carry=%b want 0 %b", i, n, cy, i == 4);
      end
      @(negedge clk);
    end
    checks++;
    if (mq[0].size() !== 4) begin
      errors++;
      $display("FAIL fill_count got %0d want 4", mq[0].size());
    end
    start_req(0, 0, 1, 1, 32'hCAFE0001, st, rd);
    checks++;
    if (st !== 1) begin
      errors++;
      $display("FAIL fill_block_stall0 got %b want 1", st);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (cpu_stall !== 1 || cpu_done !== 0) begin
        errors++;
        $display("FAIL fill_block_hold stall=%b done=%b want 1 0", cpu_stall, cpu_done);
      end
    end
    @(negedge clk);
    fsl_m_full[0] = 0;
    mq[0].push_back({1'b1, 32'hCAFE0001});
    #1;
    checks++;
    if (cpu_stall !== 1 || fsl_m_write[0] !== 1) begin
      errors++;
      $display("FAIL fill_release stall=%b write=%b want 1 1", cpu_stall, fsl_m_write[0]);
    end
    @(negedge clk);
    wait_done(4, n, rdv, cy, ce);
    checks++;
    if (n !== 1 || cy !== 0) begin
      errors++;
      $display("FAIL fill_block_done latency=%0d carry=%b want 1 0", n, cy);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (mq[0].size() !== 0) begin
      errors++;
      $display("FAIL fill_drain left %0d want 0", mq[0].size());
    end
  endtask

  task automatic test_get;
    logic st, cy, ce; logic [3:0] rd; logic [31:0] rdv; int n;
    @(negedge clk);
    fsl_s_exists = 0;
    start_req(1, 2, 0, 0, 0, st, rd);
    wait_done(3, n, rdv, cy, ce);
    checks++;
    if (st !== 0 || rd !== 0 || n !== 0 || cy !== 1 || rdv !== 0) begin
      errors++;
      $display("FAIL get_nb_empty st=%b rd=%b lat=%0d carry=%b rdata=%h want 0 0 0 1 0", st, rd, n, cy, rdv);
    end
    @(negedge clk);
    start_req(1, 2, 1, 0, 0, st, rd);
    #1;
    checks++;
    if (st !== 1 || rd !== 0 || cpu_stall !== 1 || fsl_s_read !== 0) begin
      errors++;
      $display("FAIL get_block_wait st=%b rd=%b stall=%b read=%b", st, rd, cpu_stall, fsl_s_read);
    end
    @(negedge clk);
    fsl_s_exists[2] = 1; fsl_s_data[95:64] = 32'h12345678; fsl_s_control[2] = 1;
    #1;
    checks++;
    if (fsl_s_read !== 4'b0100 || cpu_stall !== 1) begin
      errors++;
      $display("FAIL get_block_read read=%b stall=%b want 0100 1", fsl_s_read, cpu_stall);
    end
    @(negedge clk);
    fsl_s_exists = 0; fsl_s_data = 0; fsl_s_control = 0;
    wait_done(3, n, rdv, cy, ce);
    checks++;
    if (n !== 0 || rdv !== 32'h12345678 || ce !== 1 || cy !== 0) begin
      errors++;
      $display("FAIL get_block_resp lat=%0d rdata=%h cerr=%b carry=%b want 0 12345678 1 0", n, rdv, ce, cy);
    end
  endtask

  task automatic test_invalid_ch;
    logic st, cy, ce; logic [3:0] rd; logic [31:0] rdv; int n;
    @(negedge clk);
    fsl_s_exists = 4'hF; fsl_s_data = {4{32'hA5A5A5A5}};
    start_req(1, 6, 1, 1, 0, st, rd);
    wait_done(3, n, rdv, cy, ce);
    checks++;
    if (st !== 0 || rd !== 0 || n !== 0 || cy !== 1 || rdv !== 0 || ce !== 0) begin
      errors++;
      $display("FAIL invalid_get st=%b rd=%b lat=%0d carry=%b rdata=%h cerr=%b", st, rd, n, cy, rdv, ce);
    end
    @(negedge clk);
    fsl_s_exists = 0;
    start_req(0, 5, 1, 0, 32'h1111, st, rd);
    wait_done(3, n, rdv, cy, ce);
    checks++;
    if (st !== 0 || n !== 0 || cy !== 1) begin
      errors++;
      $display("FAIL invalid_put st=%b lat=%0d carry=%b want 0 0 1", st, n, cy);
    end
  endtask

  task automatic test_back_to_back_drain;
    logic st, cy, ce; logic [3:0] rd; logic [31:0] rdv; int n;
    @(negedge clk);
    fsl_m_full = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] c = (i % 2 == 0) ? 3'd0 : 3'd3;
      logic [31:0] d = $urandom;
      mq[c].push_back({d[0], d});
      start_req(0, c, 0, d[0], d, st, rd);
      wait_done(3, n, rdv, cy, ce);
      checks++;
      if (n !== 0 || cy !== 0) begin
        errors++;
        $display("FAIL drain_load%0d lat=%0d carry=%b want 0 0", i, n, cy);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      fsl_m_full = (k % 2 == 0) ? 4'b1001 : 4'b0000;
      @(negedge clk);
    end
    fsl_m_full = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (mq[0].size() !== 0 || mq[3].size() !== 0) begin
      errors++;
      $display("FAIL drain_complete left ch0=%0d ch3=%0d want 0 0", mq[0].size(), mq[3].size());
    end
  endtask

  task automatic test_random;
    logic st, cy, ce, g, b, ct, rdy; logic [2:0] c; logic [3:0] rd;
    logic [31:0] rdv, wd, exp_d; int n;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      fsl_m_full = 4'($urandom); fsl_s_exists = 4'($urandom); fsl_s_control = 4'($urandom);
      for (int j = 0; j < 4; j++) fsl_s_data[j*32 +: 32] = $urandom;
      g = 1'($urandom); c = 3'($urandom_range(0, 7)); ct = 1'($urandom); wd = $urandom;
      rdy = (c < 4) && (g ? fsl_s_exists[c[1:0]] : (mq[c[1:0]].size() < 4));
      b = (rdy || c >= 4) ? 1'($urandom) : 1'b0;
      exp_d = (g && rdy) ? fsl_s_data[c[1:0]*32 +: 32] : 32'h0;
      if (!g && rdy) mq[c[1:0]].push_back({ct, wd});
      start_req(g, c, b, ct, wd, st, rd);
      checks++;
      if (st !== 0 || rd !== ((g && rdy) ? 4'(1 << c) : 4'b0)) begin
        errors++;
        $display("FAIL rand%0d_issue st=%b rd=%b g=%b ch=%0d rdy=%b", k, st, rd, g, c, rdy);
      end
      wait_done(3, n, rdv, cy, ce);
      checks++;
      if (n !== 0 || cy !== !rdy || rdv !== exp_d || ce !== (g && rdy && (fsl_s_control[c[1:0]] ^ ct))) begin
        errors++;
        $display("FAIL rand%0d_resp lat=%0d carry=%b rdata=%h cerr=%b want carry=%b rdata=%h", k, n, cy, rdv, ce, !rdy, exp_d);
      end
    end
    @(negedge clk);
    fsl_m_full = 0; fsl_s_exists = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() !== 0) begin
      errors++;
      $display("FAIL rand_drain words left %0d want 0", mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size());
    end
  endtask

  task automatic test_reset_mid_wait;
    logic st, cy, ce; logic [3:0] rd; logic [31:0] rdv; int n;
    @(negedge clk);
    fsl_m_full = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      mq[1].push_back({1'b0, 32'h100 + i});
      start_req(0, 1, 0, 0, 32'h100 + i, st, rd);
      wait_done(3, n, rdv, cy, ce);
      @(negedge clk);
    end
    start_req(1, 2, 1, 0, 0, st, rd);
    #1;
    checks++;
    if (st !== 1 || cpu_stall !== 1) begin
      errors++;
      $display("FAIL rst_mid_setup st=%b stall=%b want 1 1", st, cpu_stall);
    end
    @(negedge clk);
    rst_n = 0; fsl_m_full = 0;
    for (int c = 0; c < 4; c++) mq[c].delete();
    #1;
    checks++;
    if ({cpu_stall, cpu_done, cpu_carry, cpu_ctrl_err, cpu_rdata, fsl_m_write, fsl_s_read, fsl_m_data, fsl_m_control} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs stall=%b done=%b mw=%b sr=%b want all 0", cpu_stall, cpu_done, fsl_m_write, fsl_s_read);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (cpu_done !== 0 || fsl_m_write !== 0) begin
        errors++;
        $display("FAIL rst_mid_after done=%b write=%b want 0 0", cpu_done, fsl_m_write);
      end
      @(negedge clk);
    end
    mq[1].push_back({1'b1, 32'hBEEF0002});
    start_req(0, 1, 1, 1, 32'hBEEF0002, st, rd);
    wait_done(3, n, rdv, cy, ce);
    checks++;
    if (st !== 0 || n !== 0 || cy !== 0) begin
      errors++;
      $display("FAIL rst_mid_put st=%b lat=%0d carry=%b want 0 0 0", st, n, cy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mq[1].size() !== 0) begin
      errors++;
      $display("FAIL rst_mid_link left %0d want 0", mq[1].size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_put_basic();
    test_fill_blocking();
    test_get();
    test_invalid_ch();
    test_back_to_back_drain();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
